// File: rtl/keyed_dut_pkg.sv
// Package: keyed_dut_pkg
// Shared types, constants and round functions for keyed_dut_seq_core.
// The functions work on vectors MAX_W bits wide and take the live width as
// an argument. Callers zero-extend their operands and keep the low bits of
// the result, so one function body serves every legal DATA_W/KEY_W.
package keyed_dut_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    EVAL  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, shifting toward the MSB.
  // The taps pick bits 7,5,4,3 of the current value.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Rotate-left by n within the low w bits. Bits at and above w come out 0.
  function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] s,
                                            input int n, input int w);
    logic [MAX_W-1:0] res;
    res = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) res[i] = s[(i + w - (n % w)) % w];
    end
    return res;
  endfunction

  // Repeat the key across the state width: kx[i] = key[i % key_w].
  function automatic logic [MAX_W-1:0] expand_key(input logic [MAX_W-1:0] key,
                                                  input int key_w, input int w);
    logic [MAX_W-1:0] kx;
    kx = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) kx[i] = key[i % key_w];
    end
    return kx;
  endfunction

  // One keyed round: rotl(s,1) ^ (s & rotl(s,3)) ^ kx ^ r.
  function automatic logic [MAX_W-1:0] keyed_round(input logic [MAX_W-1:0] s,
                                                   input logic [MAX_W-1:0] kx,
                                                   input logic [MAX_W-1:0] r,
                                                   input int w);
    return rotl(s, 1, w) ^ (s & rotl(s, 3, w)) ^ kx ^ r;
  endfunction

endpackage

// File: rtl/keyed_dut_delay_lfsr.sv
// Module: keyed_dut_delay_lfsr
// Free-running 8-bit Fibonacci LFSR that supplies the random pre-evaluation
// delay. It is only instantiated when KEYED_DUT_RAND_DELAY_EN is defined.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (loads LFSR_SEED)
//   dly    out  low two LFSR bits, the candidate delay in cycles
module keyed_dut_delay_lfsr
  import keyed_dut_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [1:0] dly
);

  logic [7:0] lfsr_reg;
  logic       feedback;

  assign feedback = ^(lfsr_reg & LFSR_TAPS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_reg <= LFSR_SEED;
    else        lfsr_reg <= {lfsr_reg[6:0], feedback};
  end

  assign dly = lfsr_reg[1:0];

endmodule

// File: rtl/keyed_dut_seq_core.sv
// Module: keyed_dut_seq_core
// Sequential logic-locked DUT for power-trace capture. A serially loaded,
// double-buffered key drives ROUNDS keyed nonlinear rounds over a DATA_W
// state, one round per clock. trigger is high exactly during the round
// cycles so the scope window covers only the evaluation.
// Optional feature macro: KEYED_DUT_RAND_DELAY_EN adds a random 0..3 cycle
// DELAY state between accept and evaluation (trigger stays low there).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   key_bit_valid/bit   serial key load into the shadow key, LSB first
//   key_commit          pulse: shadow -> active (deferred to IDLE if busy)
//   key_pending         a deferred commit is waiting for IDLE
//   in_valid/ready/data input handshake, ready only in IDLE
//   out_valid/ready/data result handshake, result held until taken
//   trigger             registered scope trigger, high during EVAL
module keyed_dut_seq_core
  import keyed_dut_pkg::*;
#(
  parameter int DATA_W = 36,
  parameter int OUT_W  = 7,
  parameter int KEY_W  = 10,
  parameter int ROUNDS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_bit_valid,
  input  logic              key_bit,
  input  logic              key_commit,
  output logic              key_pending,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              trigger
);

  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  state_e             state_reg, state_next;
  logic [KEY_W-1:0]   shadow_reg, shadow_next, active_reg;
  logic               pending_reg;
  logic [DATA_W-1:0]  s_reg;
  logic [RW-1:0]      r_reg;
  logic [OUT_W-1:0]   out_data_reg;
  logic               out_valid_reg, trigger_reg;

  logic               accept, last_round, commit_req, commit_now;
  logic [MAX_W-1:0]   s_ext, key_ext, r_ext, kx_full, round_full;

  assign accept     = (state_reg == IDLE) && in_valid;
  assign last_round = (state_reg == EVAL) && (r_reg == RW'(ROUNDS - 1));
  // A commit requested now or earlier lands on the first edge spent in IDLE.
  assign commit_req = key_commit || pending_reg;
  assign commit_now = commit_req && (state_reg == IDLE);

  generate
    if (KEY_W == 1) begin : g_shadow_one
      assign shadow_next = key_bit;
    end else begin : g_shadow_many
      assign shadow_next = {key_bit, shadow_reg[KEY_W-1:1]};
    end
  endgenerate

  // Widen operands to the package function width.
  always_comb begin
    s_ext   = '0;
    key_ext = '0;
    r_ext   = '0;
    s_ext[DATA_W-1:0] = s_reg;
    key_ext[KEY_W-1:0] = active_reg;
    r_ext[RW-1:0] = r_reg;
  end

  assign kx_full    = expand_key(key_ext, KEY_W, DATA_W);
  assign round_full = keyed_round(s_ext, kx_full, r_ext, DATA_W);

  generate
    if (DATA_W < MAX_W) begin : g_unused_hi
      logic unused_round_hi;
      assign unused_round_hi = ^round_full[MAX_W-1:DATA_W];
    end
  endgenerate

`ifdef KEYED_DUT_RAND_DELAY_EN
  logic [1:0] lfsr_dly;
  logic [1:0] delay_cnt_reg;

  keyed_dut_delay_lfsr u_delay_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .dly   (lfsr_dly)
  );

  // Loaded with the LFSR value on accept; counts the DELAY cycles left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delay_cnt_reg <= '0;
    end else if (accept) begin
      delay_cnt_reg <= lfsr_dly;
    end else if (state_reg == DELAY) begin
      delay_cnt_reg <= delay_cnt_reg - 2'd1;
    end
  end
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
`ifdef KEYED_DUT_RAND_DELAY_EN
          state_next = (lfsr_dly == 2'd0) ? EVAL : DELAY;
`else
          state_next = EVAL;
`endif
        end
      end
      DELAY: begin
`ifdef KEYED_DUT_RAND_DELAY_EN
        if (delay_cnt_reg == 2'd1) state_next = EVAL;
`else
        state_next = IDLE;  // unreachable without the delay feature
`endif
      end
      EVAL: begin
        if (last_round) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      shadow_reg    <= '0;
      active_reg    <= '0;
      pending_reg   <= 1'b0;
      s_reg         <= '0;
      r_reg         <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      trigger_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      out_valid_reg <= (state_next == DONE);
      trigger_reg   <= (state_next == EVAL);

      if (key_bit_valid) shadow_reg <= shadow_next;
      // Uses the pre-shift shadow when a shift and a commit coincide.
      if (commit_now) active_reg <= shadow_reg;
      pending_reg <= commit_req && (state_reg != IDLE);

      if (accept) begin
        s_reg <= in_data;
        r_reg <= '0;
      end else if (state_reg == EVAL) begin
        s_reg <= round_full[DATA_W-1:0];
        r_reg <= r_reg + RW'(1);
      end

      if (last_round) out_data_reg <= round_full[OUT_W-1:0];
    end
  end

  assign key_pending = pending_reg;
  assign in_ready    = (state_reg == IDLE);
  assign out_valid   = out_valid_reg;
  assign out_data    = out_data_reg;
  assign trigger     = trigger_reg;

endmodule
